// File: rtl/rvv_backend_div_unit_divider_mb_if.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_div_unit_divider_mb_if
// Purpose  : Operand/result handshake bundle between DIV operand dispatch and
//            the multi-bit iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
interface rvv_backend_div_unit_divider_mb_if #(
  parameter int DIV_WIDTH = 32,
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  // 1 = DIV_SIGN (signed), 0 = unsigned
  logic                 opcode;
  logic [DIV_WIDTH-1:0] src2_dividend;
  logic [DIV_WIDTH-1:0] src1_divisor;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [DIV_WIDTH-1:0] result_quotient;
  logic [DIV_WIDTH-1:0] result_remainder;
  logic [TAG_WIDTH-1:0] result_tag;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output in_valid, opcode, src2_dividend, src1_divisor, in_tag, result_ready,
    input  in_ready, result_quotient, result_remainder, result_tag, result_valid
  );

  modport slave (
    input  in_valid, opcode, src2_dividend, src1_divisor, in_tag, result_ready,
    output in_ready, result_quotient, result_remainder, result_tag, result_valid
  );
endinterface
`default_nettype wire

// File: rtl/rvv_backend_div_unit_divider_mb.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_div_unit_divider_mb
// Purpose  : Multi-bit-per-cycle restoring integer divider with leading-zero
//            normalisation, valid/ready input and tag pass-through.
//            Optional result reuse store: DIV_RESULT_REUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_backend_div_unit_divider_mb #(
  parameter int DIV_WIDTH      = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_WIDTH      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trap_flush_rvv,
  rvv_backend_div_unit_divider_mb_if.slave bus
);

  localparam int c_cnt_w = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [DIV_WIDTH-1:0] r_q;
  logic [DIV_WIDTH-1:0] r_rem;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic                 r_q_sgn;
  logic                 r_r_sgn;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_q_sgn;
  logic                 w_r_sgn;
  logic [DIV_WIDTH-1:0] w_abs_a;
  logic [DIV_WIDTH-1:0] w_abs_b;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_a_zero;
  logic                 w_special;
  logic                 w_reuse_hit;
  logic [c_cnt_w-1:0]   w_clz;
  logic [c_cnt_w-1:0]   w_sig;
  logic [DIV_WIDTH-1:0] w_preload;
  logic [DIV_WIDTH-1:0] w_step_q;
  logic [DIV_WIDTH-1:0] w_step_r;
  logic [DIV_WIDTH:0]   w_rem_ext;
  logic                 w_last;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 w_valid;

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  assign w_accept   = bus.in_valid & (r_state == S_IDLE) & ~trap_flush_rvv;
  assign w_a_neg    = bus.opcode & bus.src2_dividend[DIV_WIDTH-1];
  assign w_b_neg    = bus.opcode & bus.src1_divisor[DIV_WIDTH-1];
  assign w_q_sgn    = w_a_neg ^ w_b_neg;
  assign w_r_sgn    = w_a_neg;
  assign w_abs_a    = w_a_neg ? -bus.src2_dividend : bus.src2_dividend;
  assign w_abs_b    = w_b_neg ? -bus.src1_divisor : bus.src1_divisor;
  assign w_div_zero = (bus.src1_divisor == '0);
  assign w_ovf      = bus.opcode
                    & (bus.src2_dividend == {1'b1, {(DIV_WIDTH-1){1'b0}}})
                    & (bus.src1_divisor == '1);
  assign w_a_zero   = (bus.src2_dividend == '0);
  assign w_special  = w_div_zero | w_ovf | w_a_zero;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_clz = c_cnt_w'(DIV_WIDTH);
    for (int i = 0; i < DIV_WIDTH; i++) begin
      if (w_abs_a[i]) w_clz = c_cnt_w'(DIV_WIDTH - 1 - i);
    end
  end

  assign w_sig     = c_cnt_w'(DIV_WIDTH) - w_clz;
  assign w_preload = w_abs_a << w_clz;

  // ---------------------------------------------------------------------------
  // Restoring steps: r_q holds the unconsumed dividend bits at the top and
  // collects quotient bits at the bottom.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_step_q  = r_q;
    w_step_r  = r_rem;
    w_rem_ext = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (c_cnt_w'(k) < r_cnt) begin
        w_rem_ext = {w_step_r, w_step_q[DIV_WIDTH-1]};
        w_step_q  = {w_step_q[DIV_WIDTH-2:0], 1'b0};
        if (w_rem_ext >= {1'b0, r_divisor}) begin
          w_rem_ext   = w_rem_ext - {1'b0, r_divisor};
          w_step_q[0] = 1'b1;
        end
        w_step_r = w_rem_ext[DIV_WIDTH-1:0];
      end
    end
  end

  assign w_last    = (r_cnt <= c_cnt_w'(BITS_PER_CYCLE));
  assign w_cnt_nxt = w_last ? '0 : (r_cnt - c_cnt_w'(BITS_PER_CYCLE));

  // ---------------------------------------------------------------------------
  // Optional reuse of the last completed normal-case division
  // ---------------------------------------------------------------------------
`ifdef DIV_RESULT_REUSE_EN
  logic                 r_ru_valid;
  logic [DIV_WIDTH-1:0] r_ru_a;
  logic [DIV_WIDTH-1:0] r_ru_b;
  logic                 r_ru_qs;
  logic                 r_ru_rs;
  logic [DIV_WIDTH-1:0] r_ru_q;
  logic [DIV_WIDTH-1:0] r_ru_r;
  logic [DIV_WIDTH-1:0] r_abs_a;

  assign w_reuse_hit = r_ru_valid & (w_abs_a == r_ru_a) & (w_abs_b == r_ru_b)
                     & (w_q_sgn == r_ru_qs) & (w_r_sgn == r_ru_rs);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ru_valid <= 1'b0;
      r_ru_a     <= '0;
      r_ru_b     <= '0;
      r_ru_qs    <= 1'b0;
      r_ru_rs    <= 1'b0;
      r_ru_q     <= '0;
      r_ru_r     <= '0;
      r_abs_a    <= '0;
    end else if (trap_flush_rvv) begin
      r_ru_valid <= 1'b0;
    end else begin
      if (w_accept && !w_special && !w_reuse_hit) r_abs_a <= w_abs_a;
      if (r_state == S_CALC && w_last) begin
        r_ru_valid <= 1'b1;
        r_ru_a     <= r_abs_a;
        r_ru_b     <= r_divisor;
        r_ru_qs    <= r_q_sgn;
        r_ru_rs    <= r_r_sgn;
        r_ru_q     <= w_step_q;
        r_ru_r     <= w_step_r;
      end
    end
  end
`else
  assign w_reuse_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_special || w_reuse_hit) ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (bus.result_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (trap_flush_rvv) w_state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_q_sgn   <= 1'b0;
      r_r_sgn   <= 1'b0;
      r_tag     <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_tag <= bus.in_tag;
      if (w_div_zero) begin
        r_q     <= '1;
        r_rem   <= bus.src2_dividend;
        r_q_sgn <= 1'b0;
        r_r_sgn <= 1'b0;
      end else if (w_ovf) begin
        r_q     <= bus.src2_dividend;
        r_rem   <= '0;
        r_q_sgn <= 1'b0;
        r_r_sgn <= 1'b0;
      end else if (w_a_zero) begin
        r_q     <= '0;
        r_rem   <= '0;
        r_q_sgn <= 1'b0;
        r_r_sgn <= 1'b0;
`ifdef DIV_RESULT_REUSE_EN
      end else if (w_reuse_hit) begin
        r_q     <= r_ru_q;
        r_rem   <= r_ru_r;
        r_q_sgn <= w_q_sgn;
        r_r_sgn <= w_r_sgn;
`endif
      end else begin
        r_q       <= w_preload;
        r_rem     <= '0;
        r_divisor <= w_abs_b;
        r_q_sgn   <= w_q_sgn;
        r_r_sgn   <= w_r_sgn;
        r_cnt     <= w_sig;
      end
    end else if (r_state == S_CALC && !trap_flush_rvv) begin
      r_q   <= w_step_q;
      r_rem <= w_step_r;
      r_cnt <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, forced to zero outside DONE
  // ---------------------------------------------------------------------------
  assign w_valid              = (r_state == S_DONE);
  assign bus.in_ready         = (r_state == S_IDLE);
  assign bus.result_valid     = w_valid;
  assign bus.result_quotient  = w_valid ? (r_q_sgn ? -r_q : r_q) : '0;
  assign bus.result_remainder = w_valid ? (r_r_sgn ? -r_rem : r_rem) : '0;
  assign bus.result_tag       = w_valid ? r_tag : '0;

endmodule
`default_nettype wire

// File: tb/tb_rvv_backend_div_unit_divider_mb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvv_backend_div_unit_divider_mb
// Purpose  : Self-checking bench for the multi-bit divider against an
//            arithmetic reference model (results, latency, handshake).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvv_backend_div_unit_divider_mb;
  localparam int W   = 32;
  localparam int BPC = 2;
  localparam int TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trap_flush_rvv = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  rvv_backend_div_unit_divider_mb_if #(.DIV_WIDTH(W), .TAG_WIDTH(TW)) bus ();

  rvv_backend_div_unit_divider_mb #(
    .DIV_WIDTH(W), .BITS_PER_CYCLE(BPC), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .trap_flush_rvv(trap_flush_rvv), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef DIV_RESULT_REUSE_EN
  bit          m_ru_valid = 0;
  logic [W-1:0] m_ru_a, m_ru_b;
  bit          m_ru_qs, m_ru_rs;
`endif

  // Reference: native wide arithmetic plus the defined special cases
  function automatic void model_div(input logic [W-1:0] a, b, input logic sgn,
                                    output logic [W-1:0] q, r);
    longint sa, sb;
    if (b == 0) begin q = '1; r = a; end
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
    else begin
      if (sgn) begin sa = $signed(a); sb = $signed(b); end
      else begin sa = {32'd0, a}; sb = {32'd0, b}; end
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, b, input logic sgn);
    return (b == 0) || (a == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, b, input logic sgn);
    logic [W-1:0] ua, ub;
    int sig;
    if (is_special(a, b, sgn)) return 1;
    ua = (sgn && a[W-1]) ? -a : a;
    ub = (sgn && b[W-1]) ? -b : b;
`ifdef DIV_RESULT_REUSE_EN
    if (m_ru_valid && ua == m_ru_a && ub == m_ru_b &&
        m_ru_qs == ((sgn && a[W-1]) ^ (sgn && b[W-1])) && m_ru_rs == (sgn && a[W-1]))
      return 1;
`endif
    sig = 0;
    for (int i = 0; i < W; i++) if (ua[i]) sig = i + 1;
    return 1 + (sig + BPC - 1) / BPC;
  endfunction

  function automatic void model_commit(input logic [W-1:0] a, b, input logic sgn);
`ifdef DIV_RESULT_REUSE_EN
    if (!is_special(a, b, sgn)) begin
      m_ru_valid = 1;
      m_ru_a  = (sgn && a[W-1]) ? -a : a;
      m_ru_b  = (sgn && b[W-1]) ? -b : b;
      m_ru_qs = (sgn && a[W-1]) ^ (sgn && b[W-1]);
      m_ru_rs = sgn && a[W-1];
    end
`endif
  endfunction

  function automatic void model_flush();
`ifdef DIV_RESULT_REUSE_EN
    m_ru_valid = 0;
`endif
  endfunction

  // Drive one operand and wait (bounded) for result_valid; does not pop.
  task automatic do_op(input logic [W-1:0] a, b, input logic sgn, input logic [TW-1:0] tag,
                       output logic [W-1:0] q, r, output logic [TW-1:0] tg, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1; bus.opcode = sgn; bus.src2_dividend = a;
    bus.src1_divisor = b; bus.in_tag = tag;
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 1;
    while (!bus.result_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    q = bus.result_quotient; r = bus.result_remainder; tg = bus.result_tag;
  endtask

  task automatic pop();
    bus.result_ready = 1;
    @(posedge clk); #1;
    bus.result_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.result_valid); else n_pass++;
    n_checks++; if (bus.result_quotient !== 0 || bus.result_remainder !== 0 || bus.result_tag !== 0)
      $display("FAIL reset_outputs got q=%h r=%h t=%h exp 0", bus.result_quotient, bus.result_remainder, bus.result_tag);
    else n_pass++;
    rst = 0;
    model_flush();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] tb [6] = '{32'd7, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic         ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] eq [6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [W-1:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 32'd0, 32'h8000_0000};
    int           el [6] = '{5, 3, 1, 1, 1, 17};
    logic [W-1:0] q, r;
    logic [TW-1:0] tg, tag;
    int lat;
    for (int i = 0; i < 6; i++) begin
      tag = TW'(i + 9);
      do_op(ta[i], tb[i], ts[i], tag, q, r, tg, lat);
      n_checks++; if (q !== eq[i]) $display("FAIL dir_q[%0d] got %h exp %h", i, q, eq[i]); else n_pass++;
      n_checks++; if (r !== er[i]) $display("FAIL dir_r[%0d] got %h exp %h", i, r, er[i]); else n_pass++;
      n_checks++; if (tg !== tag) $display("FAIL dir_tag[%0d] got %h exp %h", i, tg, tag); else n_pass++;
      n_checks++; if (lat !== el[i]) $display("FAIL dir_lat[%0d] got %0d exp %0d", i, lat, el[i]); else n_pass++;
      model_commit(ta[i], tb[i], ts[i]);
      pop();
      n_checks++; if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result_quotient !== 0)
        $display("FAIL dir_pop[%0d] got v=%b rdy=%b q=%h exp 0/1/0", i, bus.result_valid, bus.in_ready, bus.result_quotient);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] q, r, eq, er;
    logic [TW-1:0] tg;
    int lat;
    bit rose = 0;
    bus.in_valid = 1; bus.opcode = 0; bus.src2_dividend = 32'hFFFF_FFFF;
    bus.src1_divisor = 32'd3; bus.in_tag = 4'h5;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    trap_flush_rvv = 1;
    @(posedge clk); #1;
    trap_flush_rvv = 0;
    model_flush();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (bus.result_valid) rose = 1;
      @(posedge clk); #1;
    end
    n_checks++; if (rose !== 1'b0) $display("FAIL flush_valid_rose got %b exp 0", rose); else n_pass++;
    do_op(32'd9, 32'd3, 1'b0, 4'h6, q, r, tg, lat);
    model_div(32'd9, 32'd3, 1'b0, eq, er);
    n_checks++; if (q !== eq || r !== er) $display("FAIL flush_next got q=%h r=%h exp q=%h r=%h", q, r, eq, er); else n_pass++;
    model_commit(32'd9, 32'd3, 1'b0);
    pop();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q, r;
    logic [TW-1:0] tg;
    int lat, elat;
    elat = model_lat(32'd100, 32'd7, 1'b0);
    do_op(32'd100, 32'd7, 1'b0, 4'hA, q, r, tg, lat);
    n_checks++; if (lat !== elat) $display("FAIL bp_lat got %0d exp %0d", lat, elat); else n_pass++;
    model_commit(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.result_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result_quotient !== 32'd14 ||
          bus.result_remainder !== 32'd2 || bus.result_tag !== 4'hA)
        $display("FAIL bp_hold[%0d] got v=%b rdy=%b q=%h r=%h t=%h exp 1/0/e/2/a", i, bus.result_valid,
                 bus.in_ready, bus.result_quotient, bus.result_remainder, bus.result_tag);
      else n_pass++;
    end
    pop();
    elat = model_lat(32'd100, 32'd7, 1'b0);
    do_op(32'd100, 32'd7, 1'b0, 4'hB, q, r, tg, lat);
    n_checks++; if (lat !== elat) $display("FAIL repeat_lat got %0d exp %0d", lat, elat); else n_pass++;
    n_checks++; if (q !== 32'd14 || r !== 32'd2 || tg !== 4'hB)
      $display("FAIL repeat_res got q=%h r=%h t=%h exp e/2/b", q, r, tg);
    else n_pass++;
    model_commit(32'd100, 32'd7, 1'b0);
    pop();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, q, r, eq, er;
    logic [TW-1:0] tg;
    logic sgn;
    int lat, elat;
    for (int i = 0; i < 3; i++) begin
      a = 32'hFFFF_FF00 | W'(i); b = 32'd5; sgn = 1'b1;
      model_div(a, b, sgn, eq, er);
      elat = model_lat(a, b, sgn);
      do_op(a, b, sgn, TW'(i), q, r, tg, lat);
      n_checks++; if (q !== eq || r !== er || lat !== elat || tg !== TW'(i))
        $display("FAIL b2b[%0d] got q=%h r=%h l=%0d t=%h exp q=%h r=%h l=%0d", i, q, r, lat, tg, eq, er, elat);
      else n_pass++;
      model_commit(a, b, sgn);
      pop();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic [TW-1:0] tg, tag;
    logic sgn;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '1;
      sgn = 1'($urandom_range(0, 1));
      tag = TW'($urandom);
      model_div(a, b, sgn, eq, er);
      elat = model_lat(a, b, sgn);
      do_op(a, b, sgn, tag, q, r, tg, lat);
      n_checks++; if (q !== eq) $display("FAIL rand_q a=%h b=%h s=%b got %h exp %h", a, b, sgn, q, eq); else n_pass++;
      n_checks++; if (r !== er) $display("FAIL rand_r a=%h b=%h s=%b got %h exp %h", a, b, sgn, r, er); else n_pass++;
      n_checks++; if (tg !== tag) $display("FAIL rand_tag got %h exp %h", tg, tag); else n_pass++;
      n_checks++; if (lat !== elat) $display("FAIL rand_lat a=%h b=%h s=%b got %0d exp %0d", a, b, sgn, lat, elat); else n_pass++;
      model_commit(a, b, sgn);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      pop();
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.opcode = 0; bus.src2_dividend = '0;
    bus.src1_divisor = '0; bus.in_tag = '0; bus.result_ready = 0;
    test_reset();
    test_directed();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
